fetch_prefetch_unit: RTL

- Instruction-fetch front end of the 5-stage MIPS pipeline.
- Acts as the responder to the hazard logic's fetch-stall request. It holds the PC, issues in-order requests to instruction memory (variable latency), buffers returned words in a small queue, and presents one instruction per cycle to the decode register.
- Honours stallF, handles branch/jump redirects (flushing the queue and in-flight data), and reports fetch_busy so the hazard logic can freeze F/D when no instruction is available.

---
 rtl/fetch_prefetch_unit_if.sv | 41 ++++
 rtl/fetch_prefetch_unit.sv | 113 +++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-unit bus: pipeline-side controls, instruction-memory handshake and F-stage outputs.
// FETCH_PERF_EN adds the perf counter outputs.
interface fetch_prefetch_unit_if;
    logic        stallF;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        validF;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcplus4F;
    logic        fetch_busy;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_redirect_cnt;

    modport master (
        input  stallF, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, validF, instrF, pcF, pcplus4F, fetch_busy,
               perf_bubble_cnt, perf_redirect_cnt
    );
    modport slave (
        output stallF, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, validF, instrF, pcF, pcplus4F, fetch_busy,
               perf_bubble_cnt, perf_redirect_cnt
    );
`else
    modport master (
        input  stallF, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, validF, instrF, pcF, pcplus4F, fetch_busy
    );
    modport slave (
        output stallF, redirect, redirect_pc, imem_ack, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, validF, instrF, pcF, pcplus4F, fetch_busy
    );
`endif
endinterface

// File: rtl/fetch_prefetch_unit.sv
// MIPS instruction-fetch front end: credit-limited in-order prefetch into a small queue with redirect flush.
// Optional FETCH_PERF_EN adds saturating bubble/redirect counters.
module fetch_prefetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                   clk,
    input logic                   reset,
    fetch_prefetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q      [DEPTH];
    logic [31:0] tagPc  [DEPTH];
    logic [AW:0]   qRd, qWr;
    logic [AW-1:0] tRd, tWr;
    logic [CW-1:0] outstanding, dropCnt;
    logic [31:0]   fetchPc;

    logic [CW-1:0] occ;
    logic [CW:0]   used;
    logic          validF, pop, req, hs, push, respDrop;
    entry_t        head;

    assign occ    = qWr - qRd;
    assign validF = (qWr != qRd);
    assign head   = q[qRd[AW-1:0]];
    assign pop    = validF & ~bus.stallF & ~bus.redirect;

    // A pop this cycle frees its slot for a request issued now, so a 1-cycle memory streams without gaps.
    assign used = (CW+1)'(occ) + (CW+1)'(outstanding) - (CW+1)'(pop);
    assign req  = (used < (CW+1)'(DEPTH)) & ~bus.redirect & ~reset;
    assign hs   = req & bus.imem_ack;

    assign respDrop = bus.imem_rvalid & (dropCnt != '0);
    assign push     = bus.imem_rvalid & (dropCnt == '0) & ~bus.redirect;

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetchPc;
    assign bus.validF     = validF;
    assign bus.instrF     = head.instr;
    assign bus.pcF        = head.pc;
    assign bus.pcplus4F   = head.pc + 32'd4;
    assign bus.fetch_busy = ~validF;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc     <= RESET_PC;
            qRd         <= '0;
            qWr         <= '0;
            tRd         <= '0;
            tWr         <= '0;
            outstanding <= '0;
            dropCnt     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i]     <= '0;
                tagPc[i] <= '0;
            end
        end else begin
            // Tags track every issued request, dropped or not, so they retire on every rvalid.
            if (hs) begin
                tagPc[tWr] <= fetchPc;
                tWr        <= tWr + 1'b1;
            end
            if (bus.imem_rvalid)
                tRd <= tRd + 1'b1;
            outstanding <= outstanding + CW'(hs) - CW'(bus.imem_rvalid);

            if (bus.redirect) begin
                fetchPc <= bus.redirect_pc & ~32'h3;
                qRd     <= '0;
                qWr     <= '0;
                dropCnt <= outstanding - CW'(bus.imem_rvalid);
            end else begin
                if (hs)
                    fetchPc <= fetchPc + 32'd4;
                if (push) begin
                    q[qWr[AW-1:0]] <= '{pc: tagPc[tRd], instr: bus.imem_rdata};
                    qWr            <= qWr + 1'b1;
                end
                if (pop)
                    qRd <= qRd + 1'b1;
                if (respDrop)
                    dropCnt <= dropCnt - 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubbleCnt, redirectCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubbleCnt   <= '0;
            redirectCnt <= '0;
        end else begin
            if (~validF & ~bus.redirect & (bubbleCnt != '1))
                bubbleCnt <= bubbleCnt + 32'd1;
            if (bus.redirect & (redirectCnt != '1))
                redirectCnt <= redirectCnt + 32'd1;
        end
    end

    assign bus.perf_bubble_cnt   = bubbleCnt;
    assign bus.perf_redirect_cnt = redirectCnt;
`endif
endmodule
